// File: rtl/spi_frame_master_pkg.sv
// Shared types and constants for the SPI frame master.
package spi_frame_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    // SCLK idle level
    localparam bit CPOL_IDLE_LOW     = 1'b0;
    localparam bit CPOL_IDLE_HIGH    = 1'b1;
    // Which SCLK edge captures MISO
    localparam bit CPHA_SAMPLE_LEAD  = 1'b0;
    localparam bit CPHA_SAMPLE_TRAIL = 1'b1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_frame_master_if.sv
// Host-side handshake and frame data of the SPI frame master.
interface spi_frame_master_if #(
    parameter int FRAME_BITS = 40
);
    logic                  start;
    logic                  continuous;
    logic [FRAME_BITS-1:0] tx_data;
    logic                  busy;
    logic                  dout_valid;
    logic [FRAME_BITS-1:0] DOUT;

    modport master (
        input  start,
        input  continuous,
        input  tx_data,
        output busy,
        output dout_valid,
        output DOUT
    );

    modport slave (
        output start,
        output continuous,
        output tx_data,
        input  busy,
        input  dout_valid,
        input  DOUT
    );
endinterface

// File: rtl/spi_frame_master_sclk_gen.sv
// SCLK divider: registered SCLK plus leading/trailing edge strobes that
// coincide with the clk edge on which SCLK changes.
module spi_sclk_gen
    import spi_frame_master_pkg::*;
#(
    parameter int CLK_DIV = 50,
    parameter bit CPOL    = CPOL_IDLE_LOW
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic lead,
    output logic trail
);
    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic          tick;

    assign tick  = en && (div_cnt == DIV_LAST);
    assign lead  = tick && (sclk == CPOL);
    assign trail = tick && (sclk != CPOL);

    // Half-period counter and SCLK register; parked at idle level when disabled
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div_cnt <= '0;
            sclk    <= CPOL;
        end else if (tick) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_frame_master.sv
// Parametrised full-duplex SPI master: frame FSM, shift registers, bit
// counter and the DOUT/valid register around a divided SCLK generator.
module spi_frame_master
    import spi_frame_master_pkg::*;
#(
    parameter int FRAME_BITS = 40,
    parameter int CLK_DIV    = 50,
    parameter int SS_SETUP   = 10,
    parameter int GAP_CYCLES = 20,
    parameter bit CPOL       = CPOL_IDLE_LOW,
    parameter bit CPHA       = CPHA_SAMPLE_LEAD
) (
    input  logic                clk,
    input  logic                rst,
    spi_frame_master_if.master  bus,
    input  logic                MISO,
    output logic                MOSI,
    output logic                SCLK,
    output logic                SS
);
    if (CLK_DIV < 2)    begin : g_bad_div   $error("CLK_DIV must be >= 2");    end
    if (FRAME_BITS < 1) begin : g_bad_bits  $error("FRAME_BITS must be >= 1"); end
    if (SS_SETUP < 1)   begin : g_bad_setup $error("SS_SETUP must be >= 1");   end
    if (GAP_CYCLES < 1) begin : g_bad_gap   $error("GAP_CYCLES must be >= 1"); end

    localparam int BW       = $clog2(FRAME_BITS + 1);
    localparam int WAIT_MAX = max3(SS_SETUP, CLK_DIV, GAP_CYCLES);
    localparam int WW       = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;

    localparam logic [WW-1:0] SETUP_LAST = WW'(SS_SETUP - 1);
    localparam logic [WW-1:0] HOLD_LAST  = WW'(CLK_DIV - 1);
    localparam logic [WW-1:0] GAP_LAST   = WW'(GAP_CYCLES - 1);
    localparam logic [BW-1:0] BITS_FULL  = BW'(FRAME_BITS);

    state_t                state;
    logic [FRAME_BITS-1:0] tx_sr;
    logic [FRAME_BITS-1:0] rx_sr;
    logic [FRAME_BITS-1:0] dout_r;
    logic [BW-1:0]         bit_cnt;
    logic [BW-1:0]         bit_cnt_next;
    logic [WW-1:0]         wait_cnt;
    logic                  busy_r;
    logic                  valid_r;
    logic                  lead;
    logic                  trail;
    logic                  sample;
    logic                  shift_out;
    logic                  frame_done;
    logic                  launch;

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV),
        .CPOL    (CPOL)
    ) u_sclk_gen (
        .clk   (clk),
        .rst   (rst),
        .en    (state == SHIFT),
        .sclk  (SCLK),
        .lead  (lead),
        .trail (trail)
    );

    assign bus.busy       = busy_r;
    assign bus.dout_valid = valid_r;
    assign bus.DOUT       = dout_r;

    // Edge roles per phase, frame completion and new-frame launch decode
    always_comb begin
        sample       = (CPHA == CPHA_SAMPLE_TRAIL) ? trail : lead;
        shift_out    = (CPHA == CPHA_SAMPLE_TRAIL) ? lead  : trail;
        bit_cnt_next = sample ? bit_cnt + 1'b1 : bit_cnt;
        // The last toggle is always a trailing edge; by then every bit has been sampled.
        frame_done   = trail && (bit_cnt_next == BITS_FULL);
        launch       = ((state == IDLE) && (bus.start || bus.continuous)) ||
                       ((state == GAP) && (wait_cnt == GAP_LAST) && bus.continuous);
    end

    // Frame FSM with registered SS/MOSI/busy/DOUT/valid
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            SS       <= 1'b1;
            MOSI     <= 1'b0;
            dout_r   <= '0;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            bit_cnt  <= '0;
            wait_cnt <= '0;
        end else begin
            valid_r <= 1'b0;
            if (launch) begin
                // With CPHA=0 the MSB is already on MOSI, so tx_sr holds the bits after it.
                tx_sr    <= (CPHA == CPHA_SAMPLE_TRAIL) ? bus.tx_data : (bus.tx_data << 1);
                MOSI     <= bus.tx_data[FRAME_BITS-1];
                rx_sr    <= '0;
                bit_cnt  <= '0;
                wait_cnt <= '0;
                SS       <= 1'b0;
                busy_r   <= 1'b1;
                state    <= SETUP;
            end else begin
                case (state)
                    IDLE: begin
                        busy_r <= 1'b0;
                    end
                    SETUP: begin
                        if (wait_cnt == SETUP_LAST) begin
                            wait_cnt <= '0;
                            state    <= SHIFT;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (sample) begin
                            rx_sr   <= (rx_sr << 1) | FRAME_BITS'(MISO);
                            bit_cnt <= bit_cnt_next;
                        end
                        if (shift_out) begin
                            MOSI  <= tx_sr[FRAME_BITS-1];
                            tx_sr <= tx_sr << 1;
                        end
                        if (frame_done) begin
                            wait_cnt <= '0;
                            state    <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (wait_cnt == HOLD_LAST) begin
                            SS       <= 1'b1;
                            dout_r   <= rx_sr;
                            valid_r  <= 1'b1;
                            wait_cnt <= '0;
                            state    <= GAP;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    GAP: begin
                        if (wait_cnt == GAP_LAST) begin
                            wait_cnt <= '0;
                            busy_r   <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: four 8-bit instances (one per SPI mode) and one
// default-parameter instance, driven by a polled SPI slave model.
module tb_spi_frame_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]  start_v, cont_v, rst_v, miso_v;
    logic [4:0]  ss_v, sclk_v, mosi_v, busy_v, valid_v;
    logic [39:0] tx_v   [5];
    logic [39:0] dout_v [5];

    for (genvar g = 0; g < 4; g++) begin : g_mode
        spi_frame_master_if #(.FRAME_BITS(8)) u_bus ();
        assign u_bus.start      = start_v[g];
        assign u_bus.continuous = cont_v[g];
        assign u_bus.tx_data    = tx_v[g][7:0];
        assign busy_v[g]        = u_bus.busy;
        assign valid_v[g]       = u_bus.dout_valid;
        assign dout_v[g]        = {32'h0, u_bus.DOUT};
        spi_frame_master #(
            .FRAME_BITS (8),
            .CLK_DIV    (2),
            .SS_SETUP   (2),
            .GAP_CYCLES (3),
            .CPOL       (((g / 2) % 2) == 1),
            .CPHA       ((g % 2) == 1)
        ) u_dut (
            .clk  (clk),
            .rst  (rst_v[g]),
            .bus  (u_bus),
            .MISO (miso_v[g]),
            .MOSI (mosi_v[g]),
            .SCLK (sclk_v[g]),
            .SS   (ss_v[g])
        );
    end

    spi_frame_master_if #(.FRAME_BITS(40)) u_bus_def ();
    assign u_bus_def.start      = start_v[4];
    assign u_bus_def.continuous = cont_v[4];
    assign u_bus_def.tx_data    = tx_v[4];
    assign busy_v[4]            = u_bus_def.busy;
    assign valid_v[4]           = u_bus_def.dout_valid;
    assign dout_v[4]            = u_bus_def.DOUT;

    spi_frame_master u_dut_def (
        .clk  (clk),
        .rst  (rst_v[4]),
        .bus  (u_bus_def),
        .MISO (miso_v[4]),
        .MOSI (mosi_v[4]),
        .SCLK (sclk_v[4]),
        .SS   (ss_v[4])
    );

    int n_asserts = 0;
    int n_fail    = 0;

    // observation state for the selected instance
    int          sel, fb, cyc, falls, hi_len, first_sclk, valid_first, s_idx, s_rxn;
    bit          cpol, cpha;
    logic        prev_ss, prev_sclk, ss_at1;
    logic [39:0] s_ret, s_rx;
    int          valid_q [$];
    int          gap_q   [$];
    logic [39:0] dout_q  [$];
    logic [39:0] cap_q   [$];
    logic [39:0] ret_q   [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] mask_of(input int bits);
        logic [63:0] m;
        m = (64'd1 << bits) - 64'd1;
        return m[39:0];
    endfunction

    task automatic select(input int idx);
        sel       = idx;
        fb        = (idx == 4) ? 40 : 8;
        cpol      = (idx == 4) ? 1'b0 : (((idx / 2) % 2) == 1);
        cpha      = (idx == 4) ? 1'b0 : ((idx % 2) == 1);
        prev_ss   = ss_v[idx];
        prev_sclk = sclk_v[idx];
    endtask

    task automatic clear_obs();
        valid_q.delete(); gap_q.delete(); dout_q.delete(); cap_q.delete(); ret_q.delete();
        falls = 0; hi_len = 0; first_sclk = -1; valid_first = -1; ss_at1 = 1'bx;
    endtask

    // One clk cycle, then act as the SPI slave on the selected instance
    task automatic tick();
        logic ss, sc, mo, is_lead;
        @(posedge clk);
        #1;
        cyc++;
        ss = ss_v[sel]; sc = sclk_v[sel]; mo = mosi_v[sel];
        if (cyc == 1) ss_at1 = ss;
        if (valid_v[sel]) begin
            if (valid_first < 0) valid_first = cyc;
            valid_q.push_back(cyc);
            dout_q.push_back(dout_v[sel]);
        end
        if (ss) hi_len++;
        else begin
            if (prev_ss) begin gap_q.push_back(hi_len); falls++; end
            hi_len = 0;
        end
        if (prev_ss && !ss) begin
            s_ret = (ret_q.size() > 0) ? ret_q.pop_front() : 40'h0;
            s_rx  = '0; s_rxn = 0; s_idx = fb - 1;
            if (!cpha) begin miso_v[sel] = s_ret[s_idx]; s_idx--; end
        end else if (!ss && (sc !== prev_sclk)) begin
            if (first_sclk < 0) first_sclk = cyc;
            is_lead = (prev_sclk == cpol);
            if (is_lead ^ cpha) begin
                s_rx = {s_rx[38:0], mo};
                s_rxn++;
            end else begin
                miso_v[sel] = (s_idx >= 0) ? s_ret[s_idx] : 1'b0;
                s_idx--;
            end
        end
        if (!prev_ss && ss && (s_rxn == fb)) cap_q.push_back(s_rx);
        prev_ss = ss; prev_sclk = sc;
    endtask

    task automatic pulse_start(input int idx);
        start_v[idx] = 1'b1;
        cyc = -1;
        tick();
        start_v[idx] = 1'b0;
    endtask

    task automatic run_frame(input int idx, input logic [39:0] tx, input logic [39:0] ret, input int budget);
        int n;
        select(idx);
        clear_obs();
        ret_q.push_back(ret);
        tx_v[idx] = tx;
        pulse_start(idx);
        n = 0;
        while (busy_v[idx] && n < budget) begin tick(); n++; end
        check("frame_completes_in_budget", busy_v[idx], 1'b0);
    endtask

    initial begin
        logic [39:0] r [3];
        logic [39:0] ta, tb_val, ra;
        logic [63:0] r64;
        int n;

        start_v = '0; cont_v = '0; rst_v = '1; miso_v = '0;
        for (int i = 0; i < 5; i++) tx_v[i] = '0;
        sel = 0; cyc = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ss",    ss_v[0],    1'b1);
        check("rst_sclk",  sclk_v[0],  1'b0);
        check("rst_sclk_cpol1", sclk_v[3], 1'b1);
        check("rst_mosi",  mosi_v[0],  1'b0);
        check("rst_dout",  dout_v[0],  40'h0);
        check("rst_valid", valid_v[0], 1'b0);
        check("rst_busy",  busy_v[0],  1'b0);
        check("rst_ss_def", ss_v[4],   1'b1);
        rst_v = '0;
        repeat (2) @(posedge clk);
        #1;

        // mode 0 timing and data
        run_frame(0, 40'h3C, 40'hA5, 200);
        check("t1_ss_low_cycle1", ss_at1, 1'b0);
        check("t1_first_sclk_cycle", first_sclk, 2 + 2);
        check("t1_valid_count", valid_q.size(), 1);
        check("t1_valid_cycle", valid_first, 2 + (2 * 8 + 1) * 2);
        check("t1_idle_cycle", cyc, 2 + (2 * 8 + 1) * 2 + 3);
        check("t1_dout", dout_v[0], 40'hA5);
        check("t1_slave_capture", (cap_q.size() > 0) ? cap_q[0] : 40'hx, 40'h3C);

        // every mode: fixed byte then a random one, idle level around the frame
        for (int m = 0; m < 4; m++) begin
            select(m);
            check($sformatf("t2_m%0d_sclk_idle_before", m), sclk_v[m], cpol);
            run_frame(m, 40'h5A, 40'h5A, 200);
            check($sformatf("t2_m%0d_dout", m), dout_v[m], 40'h5A);
            check($sformatf("t2_m%0d_capture", m), (cap_q.size() > 0) ? cap_q[0] : 40'hx, 40'h5A);
            check($sformatf("t2_m%0d_sclk_idle_after", m), sclk_v[m], cpol);
            ta = 40'($urandom_range(0, 255));
            ra = 40'($urandom_range(0, 255));
            run_frame(m, ta, ra, 200);
            check($sformatf("t2_m%0d_rand_dout", m), dout_v[m], ra & mask_of(8));
            check($sformatf("t2_m%0d_rand_capture", m), (cap_q.size() > 0) ? cap_q[0] : 40'hx, ta & mask_of(8));
        end

        // continuous framing: three frames then drop continuous
        select(0);
        clear_obs();
        for (int i = 0; i < 3; i++) begin
            r[i] = 40'($urandom_range(0, 255));
            ret_q.push_back(r[i]);
        end
        tx_v[0] = 40'h01;
        cont_v[0] = 1'b1;
        cyc = -1;
        tick();
        tx_v[0] = 40'h02;
        n = 0;
        while (falls < 2 && n < 200) begin tick(); n++; end
        tx_v[0] = 40'h03;
        while (falls < 3 && n < 400) begin tick(); n++; end
        cont_v[0] = 1'b0;
        n = 0;
        while (busy_v[0] && n < 200) begin tick(); n++; end
        repeat (10) tick();
        check("t3_frames_started", falls, 3);
        check("t3_valid_pulses", valid_q.size(), 3);
        check("t3_gap1", (gap_q.size() > 1) ? gap_q[1] : -1, 3);
        check("t3_gap2", (gap_q.size() > 2) ? gap_q[2] : -1, 3);
        check("t3_frame_period", (valid_q.size() > 1) ? valid_q[1] - valid_q[0] : -1, 2 + (2 * 8 + 1) * 2 + 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t3_dout%0d", i), (dout_q.size() > i) ? dout_q[i] : 40'hx, r[i]);
            check($sformatf("t3_capture%0d", i), (cap_q.size() > i) ? cap_q[i] : 40'hx, 40'(i + 1));
        end
        check("t3_idle_after", busy_v[0], 1'b0);

        // start while busy is dropped; tx_data change mid-frame has no effect
        select(0);
        clear_obs();
        ta = 40'($urandom_range(0, 255));
        tb_val = ta ^ 40'hFF;
        ra = 40'($urandom_range(0, 255));
        ret_q.push_back(ra);
        tx_v[0] = ta;
        pulse_start(0);
        while (cyc < 4) tick();
        tx_v[0] = tb_val;
        while (cyc < 9) tick();
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        while (cyc < 120) tick();
        check("t5_single_frame", falls, 1);
        check("t5_valid_count", valid_q.size(), 1);
        check("t5_capture_first_tx", (cap_q.size() > 0) ? cap_q[0] : 40'hx, ta);
        check("t5_dout", dout_v[0], ra);

        // reset in mid-frame, then a clean frame
        select(0);
        clear_obs();
        ret_q.push_back(40'($urandom_range(0, 255)) | 40'h1);
        tx_v[0] = 40'($urandom_range(0, 255));
        pulse_start(0);
        while (cyc < 19) tick();
        rst_v[0] = 1'b1;
        tick();
        check("t4_ss_after_rst",   ss_v[0],   1'b1);
        check("t4_sclk_after_rst", sclk_v[0], 1'b0);
        check("t4_busy_after_rst", busy_v[0], 1'b0);
        check("t4_dout_after_rst", dout_v[0], 40'h0);
        rst_v[0] = 1'b0;
        repeat (60) tick();
        check("t4_no_valid", valid_q.size(), 0);
        check("t4_no_capture", cap_q.size(), 0);
        ta = 40'($urandom_range(0, 255));
        ra = 40'($urandom_range(0, 255));
        run_frame(0, ta, ra, 200);
        check("t4_fresh_dout", dout_v[0], ra);
        check("t4_fresh_capture", (cap_q.size() > 0) ? cap_q[0] : 40'hx, ta);

        // default parameters, 40-bit frame
        r64 = {$urandom(), $urandom()};
        ta = r64[39:0];
        run_frame(4, ta, 40'h0123456789, 5000);
        check("t6_valid_cycle", valid_first, 10 + (2 * 40 + 1) * 50);
        check("t6_dout", dout_v[4], 40'h0123456789);
        check("t6_capture", (cap_q.size() > 0) ? cap_q[0] : 40'hx, ta);
        check("t6_sclk_idle_after", sclk_v[4], 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
